// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its host plus the gate-level block
// it sweeps. The master side drives start/expected/dut_y; the slave is the sequencer.
interface truth_table_sequencer_if #(
   parameter int N_IN = 3
);
   localparam int TW = 2**N_IN;

   // Handshake: start is accepted only while busy is low (sequencer in IDLE).
   // busy rises the cycle after acceptance, and done pulses once at the end.
   // pass/table_out/err_count are valid from the cycle after done until the next accepted start.
   logic            start;
   logic [TW-1:0]   expected;
   logic            dut_y;
   logic [N_IN-1:0] stim;
   logic            busy;
   logic            done;
   logic            pass;
   logic [TW-1:0]   table_out;
   logic [N_IN:0]   err_count;
   logic [1:0]      state_dbg;

   modport master (
      output start, expected, dut_y,
      input  stim, busy, done, pass, table_out, err_count, state_dbg
   );

   modport slave (
      input  start, expected, dut_y,
      output stim, busy, done, pass, table_out, err_count, state_dbg
   );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps an N_IN-input combinational block through all input codes, builds its truth table
// and compares it with a latched expected table. Optional macro: TTSEQ_STOP_ON_FAIL_EN.
module truth_table_sequencer #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sequencer_if.slave bus
);
   localparam int TW = 2**N_IN;
   localparam int CW = $clog2(SETTLE + 1);

`ifdef TTSEQ_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   state_t          state;
   logic [N_IN-1:0] idx;
   logic [N_IN-1:0] stim;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   exp_r;
   logic [TW-1:0]   table_out;
   logic [N_IN:0]   err_count;
   logic            busy;
   logic            done;
   logic            pass;
   logic            mismatch;
   logic            last_row;

   assign mismatch = (bus.dut_y != exp_r[idx]);
   assign last_row = (idx == N_IN'(TW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         stim      <= '0;
         cnt       <= '0;
         exp_r     <= '0;
         table_out <= '0;
         err_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  exp_r     <= bus.expected;
                  idx       <= '0;
                  stim      <= '0;
                  table_out <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
                  cnt       <= CW'(SETTLE);
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // cnt is loaded with SETTLE, so this state lasts exactly SETTLE cycles
               if (cnt == CW'(1)) state <= SAMPLE;
               else               cnt   <= cnt - 1'b1;
            end
            SAMPLE: begin
               table_out[idx] <= bus.dut_y;
               if (mismatch) err_count <= err_count + 1'b1;
               if (last_row || (STOP_ON_FAIL && mismatch)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  stim  <= idx + 1'b1;
                  cnt   <= CW'(SETTLE);
                  state <= WAIT;
               end
            end
            DONE: begin
               // err_count already includes the final row's increment here
               pass  <= (err_count == '0);
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stim      = stim;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pass      = pass;
   assign bus.table_out = table_out;
   assign bus.err_count = err_count;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=3), each
// sequencing a small behavioural gate model, with hand-computed tables and latencies.
module tb_truth_table_sequencer;
   localparam int N_IN = 3;
   localparam int TW   = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [N_IN-1:0] exp_q[$];

   logic [N_IN-1:0] o_stim;
   logic            o_busy;
   logic            o_done;
   logic            o_pass;
   logic [TW-1:0]   o_tab;
   logic [N_IN:0]   o_err;

   truth_table_sequencer_if #(.N_IN(N_IN)) b1 ();
   truth_table_sequencer_if #(.N_IN(N_IN)) b2 ();

   truth_table_sequencer #(.N_IN(N_IN), .SETTLE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1.slave)
   );

   truth_table_sequencer #(.N_IN(N_IN), .SETTLE(3)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2.slave)
   );

   // Gate models under sequencing
   assign b1.dut_y = ~b1.stim[1] & b1.stim[0];
   assign b2.dut_y = b2.stim[2];

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap(input bit sel);
      if (sel) begin
         o_stim = b2.stim; o_busy = b2.busy; o_done = b2.done;
         o_pass = b2.pass; o_tab = b2.table_out; o_err = b2.err_count;
      end else begin
         o_stim = b1.stim; o_busy = b1.busy; o_done = b1.done;
         o_pass = b1.pass; o_tab = b1.table_out; o_err = b1.err_count;
      end
   endtask

   task automatic chk_reset_values(input string tag);
      snap(1'b0);
      chk({tag, "_stim"},  32'(o_stim), 32'h0);
      chk({tag, "_busy"},  32'(o_busy), 32'h0);
      chk({tag, "_done"},  32'(o_done), 32'h0);
      chk({tag, "_pass"},  32'(o_pass), 32'h0);
      chk({tag, "_table"}, 32'(o_tab),  32'h0);
      chk({tag, "_err"},   32'(o_err),  32'h0);
   endtask

   // Driver + scoreboard for one sweep; lat is cycles from the start edge to the done edge
   task automatic sweep(input bit sel, input logic [7:0] expv, input int settle, input int lat,
                        input bit disturb, input logic [7:0] tab, input int errs, input bit pas);
      int i;
      bit seen;
      exp_q.delete();
      for (int k = 1; k <= lat; k++) exp_q.push_back(N_IN'((k - 1) / (settle + 1)));
      @(negedge clk);
      if (sel) begin b2.start = 1'b1; b2.expected = expv; end
      else     begin b1.start = 1'b1; b1.expected = expv; end
      @(negedge clk);
      b1.start = 1'b0;
      b2.start = 1'b0;
      i = 1;
      seen = 1'b0;
      while (!seen && i <= lat + 8) begin
         snap(sel);
         if (o_done) begin
            seen = 1'b1;
         end else begin
            chk("busy_during", 32'(o_busy), 32'h1);
            if (exp_q.size() > 0) chk("stim_step", 32'(o_stim), 32'(exp_q.pop_front()));
            if (disturb && i == 5) begin
               b1.start    = 1'b1;
               b1.expected = 8'hFF;
            end else if (disturb) begin
               b1.start = 1'b0;
            end
            i++;
            @(negedge clk);
         end
      end
      b1.start = 1'b0;
      chk("done_latency", 32'(i - 1), 32'(lat));
      chk("stim_at_done", 32'(o_stim), 32'((lat - 1) / (settle + 1)));
      chk("busy_at_done", 32'(o_busy), 32'h1);
      @(negedge clk);
      snap(sel);
      chk("done_pulse_end", 32'(o_done), 32'h0);
      chk("busy_after",     32'(o_busy), 32'h0);
      chk("table_out",      32'(o_tab),  32'(tab));
      chk("err_count",      32'(o_err),  32'(errs));
      chk("pass",           32'(o_pass), 32'(pas));
   endtask

   initial begin
      int n;
      rst_n       = 1'b1;
      b1.start    = 1'b0;
      b1.expected = '0;
      b2.start    = 1'b0;
      b2.expected = '0;

      // Reset asserted before the first rising edge: values must appear without a clock
      #2 rst_n = 1'b0;
      #1 chk_reset_values("reset_async");
      @(negedge clk);
      rst_n = 1'b1;

      // Matching table
      sweep(1'b0, 8'h22, 1, 16, 1'b0, 8'h22, 0, 1'b1);

      // One mismatching row
`ifdef TTSEQ_STOP_ON_FAIL_EN
      sweep(1'b0, 8'h23, 1, 2, 1'b0, 8'h00, 1, 1'b0);
`else
      sweep(1'b0, 8'h23, 1, 16, 1'b0, 8'h22, 1, 1'b0);
`endif

      // start and expected disturbed mid-sweep
      sweep(1'b0, 8'h22, 1, 16, 1'b1, 8'h22, 0, 1'b1);

      // Reset in the middle of a sweep
      @(negedge clk);
      b1.start = 1'b1;
      b1.expected = 8'h22;
      @(negedge clk);
      b1.start = 1'b0;
      n = 0;
      while (b1.stim !== 3'd4 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("reach_stim4", 32'(b1.stim), 32'h4);
      #2 rst_n = 1'b0;
      #1 chk_reset_values("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      chk("idle_after_reset", 32'(b1.state_dbg), 32'h0);
      sweep(1'b0, 8'h22, 1, 16, 1'b0, 8'h22, 0, 1'b1);

      // Longer settle, different gate model
      sweep(1'b1, 8'hF0, 3, 32, 1'b0, 8'hF0, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
